// File: rtl/decoder_v2.sv
// Control unit for the accumulator processor: FETCH/DECODE/EXECUTE/INCREMENT sequencing,
// instruction decode, mem_req/mem_ack wait states with timeout, HALT and sticky bus error.
module decoder_v2 #(
  parameter int unsigned IR_WIDTH  = 8,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [IR_WIDTH-1:0] ir,
  input  logic                carry,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                rw,
  output logic [4:0]          alu,
  output logic                muxa,
  output logic                muxb,
  output logic                muxc,
  output logic                en_ir,
  output logic                en_da,
  output logic                en_pc,
  output logic                halted,
  output logic                bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_INCREMENT, S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_JMP    = 4'b1000;
  localparam logic [3:0] OP_JCOND  = 4'b1001;
  localparam logic [3:0] OP_INPUT  = 4'b1010;
  localparam logic [3:0] OP_OUTPUT = 4'b1110;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam logic [4:0] ALU_INC = 5'b10100;

  state_t               state, state_n;
  logic                 carry_reg, zero_reg;
  logic [CNT_WIDTH-1:0] wait_cnt;

  logic [3:0] op;
  logic [1:0] cond;
  logic       unused_ir;

  assign op        = ir[IR_WIDTH-1 -: 4];
  assign cond      = ir[IR_WIDTH-5 -: 2];
  assign unused_ir = ^ir[IR_WIDTH-7:0];

  logic [4:0] op_alu;
  logic       op_muxb, op_muxc, is_mem, wr_da, set_flags, is_jump, taken;
  logic       timeout_hit, flag_ld, err_set;

  // Per-opcode datapath controls, independent of sequencing state
  always_comb begin
    op_alu    = 5'b00000;
    op_muxb   = 1'b0;
    op_muxc   = 1'b0;
    is_mem    = 1'b0;
    wr_da     = 1'b0;
    set_flags = 1'b0;
    is_jump   = 1'b0;
    case (op)
      OP_LOAD:   begin op_alu = 5'b00011; op_muxb = 1'b1; is_mem = 1'b1; wr_da = 1'b1; end
      OP_AND:    begin op_alu = 5'b00001; op_muxb = 1'b1; is_mem = 1'b1; wr_da = 1'b1; set_flags = 1'b1; end
      OP_ADD:    begin op_alu = 5'b00000; op_muxb = 1'b1; is_mem = 1'b1; wr_da = 1'b1; set_flags = 1'b1; end
      OP_SUB:    begin op_alu = 5'b01100; op_muxb = 1'b1; is_mem = 1'b1; wr_da = 1'b1; set_flags = 1'b1; end
      OP_INPUT:  begin op_alu = 5'b00011; op_muxc = 1'b1; is_mem = 1'b1; wr_da = 1'b1; end
      OP_OUTPUT: begin op_alu = 5'b00010; op_muxc = 1'b1; is_mem = 1'b1; end
      OP_JMP, OP_JCOND: begin op_alu = 5'b00011; is_jump = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (op == OP_JMP) begin
      taken = 1'b1;
    end else if (op == OP_JCOND) begin
      case (cond)
        2'b00:   taken = zero_reg;
        2'b01:   taken = ~zero_reg;
        2'b10:   taken = carry_reg;
        default: taken = ~carry_reg;
      endcase
    end
  end

  // An ack on the last permitted wait cycle still wins over the timeout
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_WIDTH'(TIMEOUT - 1)) && !mem_ack;

  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    rw      = 1'b0;
    alu     = 5'b00000;
    muxa    = 1'b0;
    muxb    = 1'b0;
    muxc    = 1'b0;
    en_ir   = 1'b0;
    en_da   = 1'b0;
    en_pc   = 1'b0;
    halted  = 1'b0;
    flag_ld = 1'b0;
    err_set = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        en_ir   = mem_ack;
        if (mem_ack) begin
          state_n = S_DECODE;
        end else if (timeout_hit) begin
          state_n = S_HALT;
          err_set = 1'b1;
        end
      end
      S_DECODE: begin
        alu     = op_alu;
        muxb    = op_muxb;
        muxc    = op_muxc;
        state_n = (op == OP_HALT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu  = op_alu;
        muxb = op_muxb;
        muxc = op_muxc;
        if (is_mem) begin
          mem_req = 1'b1;
          rw      = (op == OP_OUTPUT);
          en_da   = wr_da & mem_ack;
          if (mem_ack) begin
            state_n = S_INCREMENT;
            flag_ld = set_flags;
          end else if (timeout_hit) begin
            state_n = S_HALT;
            err_set = 1'b1;
          end
        end else if (is_jump && taken) begin
          en_pc   = 1'b1;
          state_n = S_FETCH;
        end else begin
          state_n = S_INCREMENT;
        end
      end
      S_INCREMENT: begin
        en_pc   = 1'b1;
        muxa    = 1'b1;
        alu     = ALU_INC;
        state_n = S_FETCH;
      end
      S_HALT:  halted  = 1'b1;
      default: state_n = S_IDLE;
    endcase
  end

  // Wait counter restarts whenever the state changes
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      bus_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= state_n;
      if (flag_ld) begin
        carry_reg <= carry;
        zero_reg  <= zero;
      end
      if (err_set) bus_err <= 1'b1;
      if (state_n != state) wait_cnt <= '0;
      else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_decoder_v2.sv
// Directed bench for decoder_v2: per-instruction behavioural model checked every cycle,
// plus literal pins on latency, request counts and sticky error behaviour.
module tb_decoder_v2;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] ir = 8'h00;
  logic       carry = 1'b0, zero = 1'b0, mem_ack = 1'b0;
  logic       mem_req, rw, muxa, muxb, muxc, en_ir, en_da, en_pc, halted, bus_err;
  logic [4:0] alu;

  always #5 clk = ~clk;

  decoder_v2 #(.IR_WIDTH(8), .TIMEOUT(16), .CNT_WIDTH(5)) dut (
    .clk(clk), .clr(clr), .ir(ir), .carry(carry), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .rw(rw), .alu(alu), .muxa(muxa), .muxb(muxb), .muxc(muxc),
    .en_ir(en_ir), .en_da(en_da), .en_pc(en_pc), .halted(halted), .bus_err(bus_err)
  );

  int n_vec = 0, n_err = 0;
  int n_cyc = 0, n_req = 0, n_da = 0, n_pc = 0;
  logic m_carry = 1'b0, m_zero = 1'b0, m_bus_err = 1'b0;
  logic [14:0] e_out;
  logic [14:0] act;

  assign act = {mem_req, rw, alu, muxa, muxb, muxc, en_ir, en_da, en_pc, halted, bus_err};

  // Instruction semantics
  function automatic logic [4:0] alu_of(input logic [3:0] op);
    case (op)
      4'b0000, 4'b1010, 4'b1000, 4'b1001: return 5'b00011;
      4'b0001: return 5'b00001;
      4'b1110: return 5'b00010;
      4'b0110: return 5'b01100;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic uses_b(input logic [3:0] op);
    return op == 4'b0000 || op == 4'b0001 || op == 4'b0100 || op == 4'b0110;
  endfunction

  function automatic logic uses_c(input logic [3:0] op);
    return op == 4'b1010 || op == 4'b1110;
  endfunction

  function automatic logic jump_taken(input logic [3:0] op, input logic [1:0] cond);
    if (op == 4'b1000) return 1'b1;
    if (op != 4'b1001) return 1'b0;
    case (cond)
      2'b00:   return m_zero;
      2'b01:   return !m_zero;
      2'b10:   return m_carry;
      default: return !m_carry;
    endcase
  endfunction

  task automatic expect_out(input logic mr, input logic w, input logic [4:0] a, input logic ma,
                            input logic mb, input logic mc, input logic ei, input logic ed,
                            input logic ep, input logic h);
    e_out = {mr, w, a, ma, mb, mc, ei, ed, ep, h, m_bus_err};
  endtask

  task automatic chk();
    @(negedge clk);
    n_vec++;
    n_cyc++;
    n_req += int'(mem_req);
    n_da  += int'(en_da);
    n_pc  += int'(en_pc);
    if (act !== e_out) begin
      n_err++;
      $display("FAIL outputs @%0t ir=%h act=%b exp=%b (req rw alu ma mb mc ir da pc h err)",
               $time, ir, act, e_out);
    end
  endtask

  task automatic lit(input string name, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", name, a, e);
    end
  endtask

  task automatic next_cycle(input logic ack, input logic c, input logic z);
    @(posedge clk);
    #1;
    mem_ack = ack;
    carry   = c;
    zero    = z;
  endtask

  task automatic halt_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      next_cycle(1'b1, 1'b1, 1'b1);
      expect_out(0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
      chk();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clr = 1'b1;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_carry = 1'b0; m_zero = 1'b0; m_bus_err = 1'b0;
    expect_out(0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
    chk();
  endtask

  // One instruction from FETCH; fw/ew are wait cycles before ack, clr_at asserts clr in EXECUTE
  task automatic run_instr(input logic [7:0] iv, input int fw, input int ew,
                           input logic c, input logic z, input int clr_at);
    logic [3:0] op;
    logic [1:0] cond;
    logic       ack, mem, tk;
    op   = iv[7:4];
    cond = iv[3:2];
    mem  = (op == 4'b0000 || op == 4'b0001 || op == 4'b0100 || op == 4'b0110 ||
            op == 4'b1010 || op == 4'b1110);
    for (int i = 0; i < 1000; i++) begin
      ack = (i == fw);
      next_cycle(ack, 1'b0, 1'b0);
      ir = iv;
      expect_out(1, 0, 5'd0, 0, 0, 0, ack, 0, 0, 0);
      chk();
      if (ack) break;
      if (i == TO - 1) begin m_bus_err = 1'b1; halt_cycles(3); return; end
    end
    next_cycle(1'b1, 1'b0, 1'b0);
    expect_out(0, 0, alu_of(op), 0, uses_b(op), uses_c(op), 0, 0, 0, 0);
    chk();
    if (op == 4'b1111) begin halt_cycles(3); return; end
    if (mem) begin
      for (int i = 0; i < 1000; i++) begin
        ack = (i == ew);
        if (i == clr_at) begin
          next_cycle(1'b0, ~c, ~z);
          clr = 1'b1;
          expect_out(1, op == 4'b1110, alu_of(op), 0, uses_b(op), uses_c(op), 0, 0, 0, 0);
          chk();
          next_cycle(1'b0, 1'b0, 1'b0);
          clr = 1'b0;
          m_carry = 1'b0; m_zero = 1'b0; m_bus_err = 1'b0;
          expect_out(0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
          chk();
          return;
        end
        next_cycle(ack, ack ? c : ~c, ack ? z : ~z);
        expect_out(1, op == 4'b1110, alu_of(op), 0, uses_b(op), uses_c(op), 0,
                   ack && op != 4'b1110, 0, 0);
        chk();
        if (ack) begin
          if (op == 4'b0001 || op == 4'b0100 || op == 4'b0110) begin
            m_carry = c; m_zero = z;
          end
          break;
        end
        if (i == TO - 1) begin m_bus_err = 1'b1; halt_cycles(3); return; end
      end
    end else begin
      next_cycle(1'b0, c, z);
      tk = jump_taken(op, cond);
      expect_out(0, 0, alu_of(op), 0, 0, 0, 0, 0, tk, 0);
      chk();
      if (tk) return;
    end
    next_cycle(1'b1, 1'b0, 1'b0);
    expect_out(0, 0, 5'b10100, 1, 0, 0, 0, 0, 1, 0);
    chk();
  endtask

  int c0, r0, d0, p0;

  initial begin
    do_reset();
    // LOAD, zero wait: 4 cycles
    c0 = n_cyc;
    run_instr(8'h05, 0, 0, 1'b0, 1'b0, -1);
    lit("load_cycles", n_cyc - c0, 4);

    // ADD with delayed acks, then JCOND C taken
    r0 = n_req; d0 = n_da;
    run_instr(8'h40, 1, 3, 1'b1, 1'b0, -1);
    lit("add_req_cycles", n_req - r0, 6);
    lit("add_en_da_pulses", n_da - d0, 1);
    c0 = n_cyc; p0 = n_pc;
    run_instr(8'h98, 0, 0, 1'b0, 1'b0, -1);
    lit("jc_taken_cycles", n_cyc - c0, 3);
    lit("jc_taken_pc", n_pc - p0, 1);

    // JCOND NC not taken with carry set
    c0 = n_cyc; p0 = n_pc;
    run_instr(8'h9C, 0, 0, 1'b0, 1'b0, -1);
    lit("jnc_cycles", n_cyc - c0, 4);
    lit("jnc_pc", n_pc - p0, 1);

    // OUTPUT with waits, flags must survive
    r0 = n_req; d0 = n_da;
    run_instr(8'hE0, 0, 2, 1'b0, 1'b1, -1);
    lit("out_req_cycles", n_req - r0, 4);
    lit("out_en_da", n_da - d0, 0);
    run_instr(8'h98, 0, 0, 1'b0, 1'b0, -1);

    // Mixed coverage: SUB sets zero, JCOND Z/NZ, AND, INPUT, NOP, JMP
    run_instr(8'h60, 0, 1, 1'b0, 1'b1, -1);
    run_instr(8'h90, 0, 0, 1'b0, 1'b0, -1);
    run_instr(8'h94, 2, 0, 1'b0, 1'b0, -1);
    run_instr(8'h10, 0, 0, 1'b1, 1'b0, -1);
    run_instr(8'h90, 0, 0, 1'b0, 1'b0, -1);
    run_instr(8'hA3, 0, 1, 1'b0, 1'b0, -1);
    run_instr(8'h20, 0, 0, 1'b0, 1'b0, -1);
    run_instr(8'h80, 0, 0, 1'b0, 1'b0, -1);

    // Ack on the final permitted wait cycle wins over timeout
    run_instr(8'h05, 15, 15, 1'b0, 1'b0, -1);
    lit("late_ack_no_err", int'(bus_err), 0);

    // Fetch timeout
    r0 = n_req;
    run_instr(8'h05, 99, 0, 1'b0, 1'b0, -1);
    lit("timeout_req_cycles", n_req - r0, 16);
    lit("timeout_halted", int'(halted), 1);
    lit("timeout_bus_err", int'(bus_err), 1);
    do_reset();
    lit("reset_bus_err", int'(bus_err), 0);

    // Execute timeout
    run_instr(8'h40, 0, 99, 1'b0, 1'b0, -1);
    lit("exec_timeout_err", int'(bus_err), 1);
    do_reset();

    // HALT instruction
    run_instr(8'hF0, 0, 0, 1'b0, 1'b0, -1);
    lit("halt_halted", int'(halted), 1);
    do_reset();

    // clr mid-EXECUTE wait clears flags
    run_instr(8'h40, 0, 0, 1'b1, 1'b0, -1);
    run_instr(8'h40, 0, 5, 1'b0, 1'b0, 2);
    p0 = n_pc;
    run_instr(8'h98, 0, 0, 1'b0, 1'b0, -1);
    lit("flags_cleared_by_clr", n_pc - p0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/decoder_v2.md
Name: decoder_v2

Overview:
- Second-generation control unit for the accumulator processor.
- Sequences FETCH/DECODE/EXECUTE/INCREMENT and decodes the IR into ALU, mux, memory and register-enable controls.
- Adds over the first generation:
  - a parametrised IR width;
  - a mem_req/mem_ack wait-state handshake with timeout;
  - a HALT instruction;
  - direct jump redirect that skips INCREMENT;
  - a corrected jump-if-no-carry condition.
- Sits between the IR/flag sources and the datapath muxes, ALU, accumulator and PC.

Parameters:
- IR_WIDTH, 8, instruction width (>=8). Opcode is ir[IR_WIDTH-1 -: 4]; jump condition is ir[IR_WIDTH-5 -: 2].
- TIMEOUT, 16, maximum wait cycles for mem_ack. 0 disables the timeout.
- CNT_WIDTH, 5, width of the wait counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  reset; synchronous, active-high
- ir  in  IR_WIDTH  instruction register contents
- carry  in  1  ALU carry out
- zero  in  1  ALU zero out
- mem_ack  in  1  memory transfer complete this cycle
- mem_req  out  1  memory access request
- rw  out  1  1 = write (OUTPUT)
- alu  out  5  ALU function code
- muxa, muxb, muxc  out  1 each  datapath mux selects
- en_ir, en_da, en_pc  out  1 each  IR, accumulator and PC load enables
- halted  out  1  core stopped
- bus_err  out  1  sticky memory timeout flag

Behaviour:
- **Opcodes:**
  - LOAD 0000, AND 0001, ADD 0100, SUB 0110, JMP 1000, JCOND 1001, INPUT 1010, OUTPUT 1110, HALT 1111.
  - Any other opcode is a NOP.
  - JCOND condition: 00 = Z, 01 = NZ, 10 = C, 11 = NC.
  - Memory-class ops: LOAD, AND, ADD, SUB, INPUT, OUTPUT.
- **Reset:** clr=1 at a rising edge forces the following, regardless of current state (including mid-wait):
  - state IDLE, carry_reg=0, zero_reg=0, bus_err=0, wait counter 0;
  - all outputs 0 while in IDLE.
- **State transitions:**
  - IDLE → FETCH unconditionally.
  - FETCH: mem_req=1, en_ir=mem_ack. Go to DECODE on mem_ack, else stay.
  - DECODE: one cycle. HALT opcode → HALT state; otherwise → EXECUTE.
  - EXECUTE, memory-class op: mem_req=1; rw=1 for the whole state if OUTPUT; en_da=mem_ack for LOAD/AND/ADD/SUB/INPUT. Go to INCREMENT on mem_ack.
  - EXECUTE, JMP/JCOND: one cycle. If taken: en_pc=1, next FETCH (INCREMENT skipped). If not taken: next INCREMENT.
  - EXECUTE, NOP: one cycle, → INCREMENT.
  - INCREMENT: en_pc=1, muxa=1, alu=10100, → FETCH.
  - HALT: halted=1, all other outputs 0. Exits only via clr.
- **Jump taken:** JMP always. JCOND Z: zero_reg=1. NZ: zero_reg=0. C: carry_reg=1. NC: carry_reg=0.
- **Flags:** carry_reg and zero_reg load carry/zero on the EXECUTE mem_ack cycle of ADD, SUB or AND only. All other instructions hold them.
- **alu code in DECODE/EXECUTE:**
  - LOAD, INPUT, JMP, JCOND: 00011
  - AND: 00001
  - OUTPUT: 00010
  - ADD, NOP: 00000
  - SUB: 01100
- **alu code in other states:** 00000, except INCREMENT.
- **Mux selects in DECODE/EXECUTE:** muxb=1 for LOAD/AND/ADD/SUB; muxc=1 for INPUT/OUTPUT. Both are 0 elsewhere.
- **Timeout:**
  - The counter clears on entry to FETCH or EXECUTE and increments each cycle mem_req=1 with mem_ack=0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with mem_ack still 0, the next state is HALT and bus_err sets (sticky).
  - mem_ack arriving on that same cycle wins: normal transition, no error.
- **Ack outside a request:** mem_ack while mem_req=0 is ignored.
- **Latency:** a zero-wait instruction takes 4 cycles. A taken jump takes 3 cycles.

Test Plan:
1. Reset, then LOAD (ir=0x05) with mem_ack tied 1 → states IDLE,F,D,E,I,F. en_ir pulses in F, en_da in E, en_pc in I. alu=00011 in D/E, 10100 in I.
2. ADD with ack delayed 3 cycles in EXECUTE; ALU carry=1, zero=0 on the ack cycle → mem_req held 4 cycles, en_da single pulse on ack, carry_reg=1. A following JCOND C (0x98) gives en_pc=1 in EXECUTE, then FETCH directly.
3. JCOND NC (0x9C) with carry_reg=1, zero_reg=0 → not taken; en_pc=0 in EXECUTE, en_pc=1 in INCREMENT.
4. TIMEOUT=16, no mem_ack in FETCH → after 16 request cycles state is HALT, bus_err=1, halted=1, all enables 0. clr=1 for one edge → IDLE, bus_err=0.
5. OUTPUT (0xE0) with 2 wait cycles → rw=1 and muxc=1 for all 3 EXECUTE cycles, en_da=0, flags unchanged.
6. HALT (0xF0) → halted=1 the cycle after DECODE, mem_req=0 thereafter. clr asserted mid-EXECUTE wait on another run → IDLE next edge.
